// File: rtl/multi_edge_counter_pkg.sv
// Shared definitions for the multi-channel edge counter: edge-mode encoding,
// default parameter values and the edge-select helper.
package multi_edge_counter_pkg;

  // Run-time edge selection, shared by all channels.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  localparam int unsigned CHANNELS_DEF     = 4;
  localparam int unsigned WIDTH_DEF        = 8;
  localparam int unsigned SYNC_STAGES_DEF  = 2;
  localparam int unsigned DEBOUNCE_LEN_DEF = 4;

  // Picks the countable event out of the detected rise/fall pair.
  function automatic logic edge_event(input edge_mode_e mode,
                                      input logic       rise,
                                      input logic       fall);
    logic evt;
    case (mode)
      EDGE_RISE: evt = rise;
      EDGE_FALL: evt = fall;
      EDGE_BOTH: evt = rise | fall;
      default:   evt = 1'b0;
    endcase
    return evt;
  endfunction

endpackage

// File: rtl/edge_count_channel.sv
// One counter channel: input synchroniser, optional debounce filter, edge
// detector and wrapping/saturating counter with overflow and threshold pulse.
// Optional feature: define MULTI_EDGE_DEBOUNCE_EN to build the debounce filter.
module edge_count_channel
  import multi_edge_counter_pkg::*;
#(
  parameter int unsigned WIDTH        = WIDTH_DEF,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF
`ifdef MULTI_EDGE_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_LEN = DEBOUNCE_LEN_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_in,
  input  logic [1:0]       edge_mode,
  input  logic             saturate,
  input  logic             clear,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             thresh_hit
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   filt;
  logic                   p;
  logic                   rise;
  logic                   fall;
  logic                   evt;
  logic [WIDTH-1:0]       cnt_inc;
  logic                   at_max;

  // Synchroniser chain; the last stage is the first usable sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignment lets every stage shift off the same old values.
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_LEN + 1);

  logic [DbW-1:0] db_cnt;

  // Debounce: follow s only once it has disagreed with filt for DEBOUNCE_LEN cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (s == filt) begin
      db_cnt <= '0;
    end else if (db_cnt == DbW'(DEBOUNCE_LEN - 1)) begin
      db_cnt <= '0;
      filt   <= s;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  assign filt = s;
`endif

  // Previous filtered sample; keeps running through clear and mode 11 so no edge is replayed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= 1'b0;
    end else begin
      p <= filt;
    end
  end

  // Edge detect and mode select.
  always_comb begin
    // NOTE: every always_comb output is assigned up front so no path can infer a latch.
    rise    = filt & ~p;
    fall    = ~filt & p;
    evt     = edge_event(edge_mode_e'(edge_mode), rise, fall);
    cnt_inc = count + 1'b1;
    at_max  = &count;
  end

  // Counter, sticky overflow and one-cycle threshold pulse; clear wins over a coincident event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      overflow   <= 1'b0;
      thresh_hit <= 1'b0;
    end else if (clear) begin
      count      <= '0;
      overflow   <= 1'b0;
      thresh_hit <= 1'b0;
    end else begin
      thresh_hit <= 1'b0;
      if (evt) begin
        if (!at_max) begin
          count      <= cnt_inc;
          thresh_hit <= (cnt_inc == threshold);
        end else begin
          overflow <= 1'b1;
          if (!saturate) begin
            count      <= '0;
            thresh_hit <= (threshold == '0);
          end
        end
      end
    end
  end

endmodule

// File: rtl/multi_edge_counter.sv
// Multi-channel asynchronous edge counter: CHANNELS independent copies of
// edge_count_channel sharing mode, saturate, clear and threshold controls.
// Optional feature: define MULTI_EDGE_DEBOUNCE_EN to add a per-channel
// debounce filter of DEBOUNCE_LEN cycles ahead of the edge detector.
module multi_edge_counter
  import multi_edge_counter_pkg::*;
#(
  parameter int unsigned CHANNELS     = CHANNELS_DEF,
  parameter int unsigned WIDTH        = WIDTH_DEF,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_LEN = DEBOUNCE_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       ext_in,
  input  logic [1:0]                edge_mode,
  input  logic                      saturate,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          threshold,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       overflow,
  output logic [CHANNELS-1:0]       thresh_hit
);

  // Reject configurations outside the supported ranges at elaboration time.
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("multi_edge_counter: CHANNELS must be 1..16");
  end
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("multi_edge_counter: WIDTH must be 2..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("multi_edge_counter: SYNC_STAGES must be 2..3");
  end
  if (DEBOUNCE_LEN < 1) begin : g_bad_debounce
    $error("multi_edge_counter: DEBOUNCE_LEN must be at least 1");
  end

  // One independent channel per input bit; outputs are packed channel 0 first.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_count_channel #(
      .WIDTH        (WIDTH),
      .SYNC_STAGES  (SYNC_STAGES)
`ifdef MULTI_EDGE_DEBOUNCE_EN
      ,
      .DEBOUNCE_LEN (DEBOUNCE_LEN)
`endif
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .ext_in     (ext_in[i]),
      .edge_mode  (edge_mode),
      .saturate   (saturate),
      .clear      (clear),
      .threshold  (threshold),
      .count      (count[i*WIDTH +: WIDTH]),
      .overflow   (overflow[i]),
      .thresh_hit (thresh_hit[i])
    );
  end

endmodule

// File: tb/tb_multi_edge_counter.sv
// Scoreboard bench for multi_edge_counter (CHANNELS=4, WIDTH=8, SYNC_STAGES=2).
// Stimulus pushes expected snapshots and expected threshold pulses into
// queues; a monitor on the falling clock edge pops and compares.
module tb_multi_edge_counter;

`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int LAT = 2 + 4;
`else
  localparam int LAT = 2;
`endif
  localparam int HOLD = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ext_in;
  logic [1:0]  edge_mode;
  logic        saturate;
  logic        clear;
  logic [7:0]  threshold;
  logic [31:0] count;
  logic [3:0]  overflow;
  logic [3:0]  thresh_hit;

  multi_edge_counter #(
    .CHANNELS     (4),
    .WIDTH        (8),
    .SYNC_STAGES  (2),
    .DEBOUNCE_LEN (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ext_in     (ext_in),
    .edge_mode  (edge_mode),
    .saturate   (saturate),
    .clear      (clear),
    .threshold  (threshold),
    .count      (count),
    .overflow   (overflow),
    .thresh_hit (thresh_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] cnt;
    logic [3:0]  ovf;
  } snap_t;

  typedef struct {
    string       name;
    logic [3:0]  mask;
    logic [31:0] cnt;
  } hit_t;

  snap_t snap_q[$];
  hit_t  hit_q[$];
  snap_t mon_s;
  hit_t  mon_h;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_cnt [4];
  logic [3:0] exp_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_exp();
    return {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
  endfunction

  task automatic push_snap(input string name);
    snap_t it;
    it.name = name;
    it.cnt  = pack_exp();
    it.ovf  = exp_ovf;
    snap_q.push_back(it);
  endtask

  task automatic push_hit(input string name, input logic [3:0] mask, input logic [31:0] cnt);
    hit_t it;
    it.name = name;
    it.mask = mask;
    it.cnt  = cnt;
    hit_q.push_back(it);
  endtask

  // Let the pipeline settle, then queue a snapshot for the next falling edge.
  task automatic snap(input string name);
    repeat (8) @(posedge clk);
    #1;
    push_snap(name);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] mask);
    @(negedge clk);
    ext_in = ext_in | mask;
    repeat (HOLD) @(negedge clk);
    ext_in = ext_in & ~mask;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 4; i++) exp_cnt[i] = 8'd0;
    exp_ovf = 4'd0;
  endtask

  // Monitor: compares queued snapshots and every threshold pulse the DUT presents.
  always @(negedge clk) begin
    if (snap_q.size() != 0) begin
      mon_s = snap_q.pop_front();
      check({mon_s.name, ".count"}, count, mon_s.cnt);
      check({mon_s.name, ".overflow"}, {28'd0, overflow}, {28'd0, mon_s.ovf});
    end
    if (thresh_hit != 4'd0) begin
      if (hit_q.size() == 0) begin
        check("unexpected_thresh_hit", {28'd0, thresh_hit}, 32'd0);
      end else begin
        mon_h = hit_q.pop_front();
        check({mon_h.name, ".hit_mask"}, {28'd0, thresh_hit}, {28'd0, mon_h.mask});
        check({mon_h.name, ".hit_count"}, count, mon_h.cnt);
      end
    end
  end

  // Watchdog: the run is fixed-length, so this only fires on a hung simulation.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    ext_in    = 4'd0;
    edge_mode = 2'b00;
    saturate  = 1'b0;
    clear     = 1'b0;
    threshold = 8'd250;
    clear_exp();

    repeat (3) @(posedge clk);
    #1;
    push_snap("reset_state");
    @(negedge clk);
    #1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    snap("after_reset");

    // First increment lands exactly LAT edges after the sampling edge.
    @(negedge clk);
    ext_in[0] = 1'b1;
    @(posedge clk);
    repeat (LAT - 1) @(posedge clk);
    #1;
    push_snap("latency_before");
    @(posedge clk);
    #1;
    exp_cnt[0] = 8'd1;
    push_snap("latency_at");
    @(negedge clk);
    ext_in[0] = 1'b0;
    repeat (HOLD) @(negedge clk);
    repeat (4) pulse(4'b0001);
    exp_cnt[0] = 8'd5;
    snap("rise_ch0_five");

    // Both edges, then falling only.
    edge_mode = 2'b10;
    repeat (3) pulse(4'b0100);
    exp_cnt[2] = 8'd6;
    snap("both_ch2_six");
    edge_mode = 2'b01;
    pulse(4'b0100);
    exp_cnt[2] = 8'd7;
    snap("fall_ch2_seven");

    // Counting disabled.
    edge_mode = 2'b11;
    pulse(4'b0010);
    snap("mode_off");
    edge_mode = 2'b00;

    // Threshold pulse fires once at count 3.
    threshold = 8'd3;
    push_hit("thresh3", 4'b0010, {8'd0, 8'd7, 8'd3, 8'd5});
    repeat (5) pulse(4'b0010);
    exp_cnt[1] = 8'd5;
    snap("thresh_ch1_five");
    threshold = 8'd250;

    // Synchronous clear.
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    clear_exp();
    snap("clear_all");

    // Saturation on ch3: hits 255 once, then holds without re-firing.
    threshold = 8'd255;
    saturate  = 1'b1;
    push_hit("sat255", 4'b1000, 32'hFF00_0000);
    repeat (258) pulse(4'b1000);
    exp_cnt[3] = 8'd255;
    exp_ovf    = 4'b1000;
    snap("saturate_hold");

    // Wrap with threshold 0 fires only on the wrap.
    saturate  = 1'b0;
    threshold = 8'd0;
    push_hit("wrap0", 4'b1000, 32'h0000_0000);
    pulse(4'b1000);
    exp_cnt[3] = 8'd0;
    snap("wrap_to_zero");
    pulse(4'b1000);
    exp_cnt[3] = 8'd1;
    snap("after_wrap");
    threshold = 8'd250;

    // Clear collides with a detected edge on ch0 at count 9.
    repeat (9) pulse(4'b0001);
    exp_cnt[0] = 8'd9;
    snap("ch0_nine");
    @(negedge clk);
    ext_in[0] = 1'b1;
    @(posedge clk);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    clear_exp();
    snap("clear_collision");
    @(negedge clk);
    ext_in[0] = 1'b0;
    snap("edge_lost");
    pulse(4'b0001);
    exp_cnt[0] = 8'd1;
    snap("after_collision");

    // Simultaneous event on every channel.
    pulse(4'b1111);
    exp_cnt[0] = 8'd2;
    exp_cnt[1] = 8'd1;
    exp_cnt[2] = 8'd1;
    exp_cnt[3] = 8'd1;
    snap("all_channels");

    // Short glitch on ch2.
    @(negedge clk);
    ext_in[2] = 1'b1;
    repeat (2) @(negedge clk);
    ext_in[2] = 1'b0;
`ifndef MULTI_EDGE_DEBOUNCE_EN
    exp_cnt[2] = 8'd2;
`endif
    snap("short_glitch");

    // Asynchronous reset mid-count, then input high across reset release.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_exp();
    push_snap("async_reset");
    @(negedge clk);
    #1;
    ext_in[1] = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    exp_cnt[1] = 8'd1;
    snap("reset_release_high");
    @(negedge clk);
    ext_in[1] = 1'b0;
    snap("final_state");

    repeat (4) @(negedge clk);
    check("thresh_hits_outstanding", hit_q.size(), 32'd0);
    check("snapshots_outstanding", snap_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
